fifo_framer: RTL and testbench
==============================

# fifo_framer

Downstream consumer of the first-word-fall-through `fifo`. It drains queued words and emits them as length-prefixed frames on a valid/ready output stream. A frame is launched when `MAX_LEN` words are queued, or when a partial batch has been waiting `TIMEOUT` cycles. It sits between the FIFO read port and the link/transport stage.

## Interface
- `WIDTH`, default 32: data word width; must satisfy `WIDTH >= $clog2(MAX_LEN+1)+1`.
- `FIFO_DEPTH`, default 512: depth of the upstream FIFO; sets the `fifo_data_count` width.
- `MAX_LEN`, default 16: maximum payload words per frame, at least 1.
- `TIMEOUT`, default 255: idle cycles before a partial frame is flushed, at least 1.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `srst_n`  in  1  reset; synchronous, active-low.
- `fifo_dout`  in  WIDTH  FIFO head word; valid while `fifo_empty`=0 (FWFT).
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data_count`  in  `$clog2(FIFO_DEPTH)`  FIFO occupancy.
- `fifo_rd_en`  out  1  pops the FIFO head; combinational.
- `m_data`  out  WIDTH  output word.
- `m_valid`  out  1  output word valid.
- `m_last`  out  1  marks the final word of a frame.
- `m_ready`  in  1  downstream accepts the word when high together with `m_valid`.

## Operation
- FSM states: IDLE, HEADER, PAYLOAD, plus TRAILER when the checksum feature is built in.
- Timer `idle_cnt` (`$clog2(TIMEOUT+1)` bits):
  - Counts only in IDLE while `fifo_empty`=0 and `fifo_data_count < MAX_LEN`.
  - Saturates at `TIMEOUT`.
  - Clears when `fifo_empty`=1 and on any exit from IDLE.
- IDLE to HEADER happens when `fifo_data_count >= MAX_LEN`, or when `fifo_empty`=0 and `idle_cnt == TIMEOUT`.
  - On that transition, `len = min(fifo_data_count, MAX_LEN)` is latched and `remaining` is loaded with `len`.
- HEADER:
  - `m_valid`=1.
  - `m_data` = bit `WIDTH-1` set, `len` zero-extended in the low bits, all other bits 0.
  - `m_last`=0.
  - On `m_valid & m_ready`, go to PAYLOAD.
- PAYLOAD:
  - `m_valid`=1 and `m_data = fifo_dout`.
  - `fifo_rd_en = m_ready` (a combinational path from `m_ready`).
  - Each accepted word decrements `remaining`.
  - `m_last` = (`remaining`==1), unless the checksum feature is built in.
  - When the word with `remaining`==1 is accepted, go to IDLE, or to TRAILER when the checksum feature is built in.
- Words are guaranteed present in PAYLOAD because `len` never exceeds the latched occupancy and the framer is the FIFO's only reader. Writes during a frame do not affect `len`.
- `fifo_rd_en` is 0 in every state other than PAYLOAD.
- While `m_valid`=1 and `m_ready`=0, `m_data` and `m_last` hold stable and no pop occurs.
- Reset (`srst_n`=0):
  - State returns to IDLE and `idle_cnt`, `remaining`, `len` and the checksum all clear.
  - `m_valid`=0, `m_last`=0, `m_data`=0, `fifo_rd_en`=0.
- Reset mid-frame aborts the frame. Words already popped are lost; unpopped words stay in the FIFO and are framed after reset.

## Timing
- Trigger seen in IDLE at cycle t: the header is valid at t+1.
- The first payload word is valid the cycle after the header is accepted.
- Payload throughput is 1 word/cycle with `m_ready` held high.
- After the last word is accepted, there is exactly one cycle in IDLE with `m_valid`=0 before the next header can appear.
  - This cycle guarantees IDLE samples a `fifo_data_count` that reflects the final pop.
- Timeout flush: with 1 to `MAX_LEN-1` words queued and no writes, the header appears `TIMEOUT+1` cycles after `fifo_empty` falls.
- Frame latency for a full batch is `len+1` cycles from header valid to last accepted, assuming no backpressure.

## Configuration
- Macro: `FIFO_FRAMER_CHECKSUM_EN`.
- Defined:
  - The checksum register clears on entering HEADER.
  - It XORs in every accepted payload word.
  - After the last payload word, the TRAILER state emits `m_data` = checksum, `m_valid`=1, `m_last`=1, then returns to IDLE on acceptance.
  - Frame length on the wire is `len+2`.
- Undefined:
  - There is no TRAILER state and no checksum register.
  - `m_last` asserts on the final payload word.
  - Frame length on the wire is `len+1`.

## Test plan
- Reset: hold `srst_n`=0 for 3 cycles with a non-empty FIFO -> `m_valid`, `m_last`, `fifo_rd_en` = 0 and `m_data`=0 throughout.
- Full batch: `MAX_LEN`=4, write 0x11, 0x22, 0x33, 0x44, `m_ready`=1 -> header 0x80000004, then 0x11..0x44, `m_last` on 0x44 (macro off).
- Timeout: `TIMEOUT`=8, write 2 words, then none -> header 0x80000002 exactly 9 cycles after `fifo_empty` falls; both words follow.
- Backpressure: during payload drop `m_ready` for 5 cycles -> `m_data` stable, `fifo_rd_en`=0, no word lost or duplicated.
- Oversize: write 10 words with `MAX_LEN`=4 -> frames of lengths 4, 4, then 2 after timeout, with one gap cycle between frames.
- Checksum (macro on): payload 0x0F, 0xF0, 0xFF -> trailer 0x00 with `m_last`=1. Also assert `srst_n`=0 after the second payload word -> the remaining FIFO word is reframed as a length-1 frame after timeout.

Source files
------------

// File: rtl/fifo_framer.sv
// Drains a FWFT FIFO into length-prefixed frames; FIFO_FRAMER_CHECKSUM_EN adds an XOR trailer.
// Latency: header one cycle after a full-batch or timeout trigger, then payload at 1 word/cycle.
// Backpressure: m_ready low holds m_data/m_last and suppresses pops; one idle gap between frames.
module fifo_framer #(
   parameter int WIDTH      = 32,
   parameter int FIFO_DEPTH = 512,
   parameter int MAX_LEN    = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                          clk,
   input  logic                          srst_n,
   input  logic [WIDTH-1:0]              fifo_dout,
   input  logic                          fifo_empty,
   input  logic [$clog2(FIFO_DEPTH)-1:0] fifo_data_count,
   output logic                          fifo_rd_en,
   output logic [WIDTH-1:0]              m_data,
   output logic                          m_valid,
   output logic                          m_last,
   input  logic                          m_ready
);
   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
   localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT);

`ifdef FIFO_FRAMER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE = 2'd0, HEADER = 2'd1, PAYLOAD = 2'd2, TRAILER = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, HEADER = 2'd1, PAYLOAD = 2'd2} state_t;
`endif

   state_t        state;
   state_t        state_nxt;
   logic [TW-1:0] idle_cnt;
   logic [LW-1:0] len;
   logic [LW-1:0] remaining;
   logic [LW-1:0] len_nxt;
   logic [31:0]   count_ext;
   logic          batch_full;
   logic          trigger;
`ifdef FIFO_FRAMER_CHECKSUM_EN
   logic [WIDTH-1:0] csum;
`endif

   assign count_ext  = 32'(fifo_data_count);
   assign batch_full = (count_ext >= 32'(MAX_LEN));
   assign trigger    = (state == IDLE) &&
                       (batch_full || (!fifo_empty && idle_cnt == TIMEOUT_T));
   // Only truncated when the occupancy is below MAX_LEN, so no bits are lost.
   assign len_nxt    = batch_full ? MAX_LEN_L : LW'(fifo_data_count);

   always_comb begin
      state_nxt  = state;
      m_valid    = 1'b0;
      m_data     = '0;
      m_last     = 1'b0;
      fifo_rd_en = 1'b0;
      case (state)
         IDLE: begin
            if (trigger) state_nxt = HEADER;
         end
         HEADER: begin
            m_valid             = 1'b1;
            m_data[WIDTH-1]     = 1'b1;
            m_data[LW-1:0]      = len;
            if (m_ready) state_nxt = PAYLOAD;
         end
         PAYLOAD: begin
            m_valid    = 1'b1;
            m_data     = fifo_dout;
            fifo_rd_en = m_ready;
`ifdef FIFO_FRAMER_CHECKSUM_EN
            if (m_ready && remaining == LW'(1)) state_nxt = TRAILER;
`else
            m_last     = (remaining == LW'(1));
            if (m_ready && remaining == LW'(1)) state_nxt = IDLE;
`endif
         end
`ifdef FIFO_FRAMER_CHECKSUM_EN
         TRAILER: begin
            m_valid = 1'b1;
            m_data  = csum;
            m_last  = 1'b1;
            if (m_ready) state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
      // Outputs are forced quiet for the whole reset, including its first cycle.
      if (!srst_n) begin
         m_valid    = 1'b0;
         m_data     = '0;
         m_last     = 1'b0;
         fifo_rd_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!srst_n) begin
         state     <= IDLE;
         idle_cnt  <= '0;
         len       <= '0;
         remaining <= '0;
`ifdef FIFO_FRAMER_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (state != IDLE || trigger || fifo_empty)
            idle_cnt <= '0;
         else if (idle_cnt != TIMEOUT_T)
            idle_cnt <= idle_cnt + TW'(1);
         if (trigger) begin
            len       <= len_nxt;
            remaining <= len_nxt;
         end else if (state == PAYLOAD && m_ready) begin
            remaining <= remaining - LW'(1);
         end
`ifdef FIFO_FRAMER_CHECKSUM_EN
         if (trigger)
            csum <= '0;
         else if (state == PAYLOAD && m_ready)
            csum <= csum ^ fifo_dout;
`endif
      end
   end
endmodule

// File: tb/tb_fifo_framer.sv
// Directed bench for fifo_framer behind a behavioural FWFT FIFO (MAX_LEN=4, TIMEOUT=8).
// Each task drives a scenario and compares observed beats/timing against hand-derived values.
// Builds with or without FIFO_FRAMER_CHECKSUM_EN; expected frames gain a trailer when it is set.
module tb_fifo_framer;
   localparam int WIDTH      = 32;
   localparam int FIFO_DEPTH = 16;
   localparam int MAX_LEN    = 4;
   localparam int TIMEOUT    = 8;
   localparam int CW         = $clog2(FIFO_DEPTH);
`ifdef FIFO_FRAMER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             srst_n = 1'b0;
   logic [WIDTH-1:0] fifo_dout;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_data_count;
   logic             fifo_rd_en;
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             m_last;
   logic             m_ready = 1'b0;

   logic             wr_en = 1'b0;
   logic [WIDTH-1:0] wr_data = '0;
   logic [WIDTH-1:0] mem [0:31];
   logic [4:0]       wptr = '0;
   logic [4:0]       rptr = '0;
   logic [5:0]       cnt = '0;
   logic             pop;
   int               underflows = 0;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   logic             s_valid, s_last, s_rd;
   logic [WIDTH-1:0] s_data;
   logic [WIDTH-1:0] bd[$];
   logic             bl[$];
   int               bc[$];
   logic [WIDTH-1:0] ed[$];
   logic             el[$];
   logic [WIDTH-1:0] pl[$];

   fifo_framer #(.WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .srst_n(srst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_data_count(fifo_data_count), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
      .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready));

   always #5 clk = ~clk;

   // FWFT FIFO model: a written word becomes the visible head on the following cycle.
   assign pop             = fifo_rd_en && (cnt != 0);
   assign fifo_dout       = mem[rptr];
   assign fifo_empty      = (cnt == 0);
   assign fifo_data_count = CW'(cnt);
   always @(posedge clk) begin
      if (wr_en) begin
         mem[wptr] <= wr_data;
         wptr      <= wptr + 5'd1;
      end
      if (pop) rptr <= rptr + 5'd1;
      if (fifo_rd_en && cnt == 0) underflows <= underflows + 1;
      cnt <= cnt + 6'(wr_en) - 6'(pop);
   end

   task automatic tick();
      #1;
      s_valid = m_valid; s_data = m_data; s_last = m_last; s_rd = fifo_rd_en;
      if (m_valid && m_ready) begin
         bd.push_back(m_data); bl.push_back(m_last); bc.push_back(cyc);
      end
      @(posedge clk); #1;
      cyc++;
      wr_en = 1'b0;
   endtask

   task automatic write_word(input logic [WIDTH-1:0] d);
      wr_en = 1'b1; wr_data = d;
      tick();
   endtask

   task automatic clear_log();
      bd.delete(); bl.delete(); bc.delete(); ed.delete(); el.delete(); pl.delete();
   endtask

   task automatic expect_frame();
      logic [WIDTH-1:0] x;
      x = '0;
      ed.push_back(32'h8000_0000 | 32'(pl.size())); el.push_back(1'b0);
      foreach (pl[i]) begin
         ed.push_back(pl[i]);
         el.push_back((i == pl.size() - 1) && !CSUM);
         x ^= pl[i];
      end
      if (CSUM) begin ed.push_back(x); el.push_back(1'b1); end
      pl.delete();
   endtask

   task automatic wait_beats(input int n, input int budget, output bit ok);
      int k = 0;
      while (bd.size() < n && k < budget) begin tick(); k++; end
      ok = (bd.size() >= n);
   endtask

   task automatic test_reset();
      bit ok;
      int r;
      clear_log();
      srst_n = 1'b0; m_ready = 1'b1;
      write_word(32'hA1);
      write_word(32'hA2);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (s_valid !== 1'b0 || s_last !== 1'b0 || s_rd !== 1'b0 || s_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs cyc%0d: valid=%b last=%b rd_en=%b data=%h, want all 0",
                     i, s_valid, s_last, s_rd, s_data);
         end
      end
      srst_n = 1'b1; r = cyc;
      pl.push_back(32'hA1); pl.push_back(32'hA2); expect_frame();
      wait_beats(ed.size(), 40, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL reset_drain: beats=%0d, want %0d", bd.size(), ed.size());
      end else begin
         for (int i = 0; i < ed.size(); i++) begin
            checks++;
            if (bd[i] !== ed[i] || bl[i] !== el[i]) begin
               failures++;
               $display("FAIL reset_drain beat%0d: data=%h last=%b, want data=%h last=%b",
                        i, bd[i], bl[i], ed[i], el[i]);
            end
         end
         checks++;
         if (bc[0] !== r + TIMEOUT + 1) begin
            failures++;
            $display("FAIL reset_drain_time: header cycle %0d, want %0d", bc[0], r + TIMEOUT + 1);
         end
      end
      tick(); tick();
   endtask

   task automatic test_full_batch();
      bit ok;
      int start;
      clear_log(); m_ready = 1'b1; start = cyc;
      write_word(32'h11); write_word(32'h22); write_word(32'h33); write_word(32'h44);
      pl.push_back(32'h11); pl.push_back(32'h22); pl.push_back(32'h33); pl.push_back(32'h44);
      expect_frame();
      wait_beats(ed.size(), 30, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL full_batch: beats=%0d, want %0d", bd.size(), ed.size());
      end else begin
         for (int i = 0; i < ed.size(); i++) begin
            checks++;
            if (bd[i] !== ed[i] || bl[i] !== el[i] || bc[i] !== start + 5 + i) begin
               failures++;
               $display("FAIL full_batch beat%0d: data=%h last=%b cyc=%0d, want data=%h last=%b cyc=%0d",
                        i, bd[i], bl[i], bc[i], ed[i], el[i], start + 5 + i);
            end
         end
      end
      tick(); tick();
   endtask

   task automatic test_timeout();
      bit ok;
      int start;
      clear_log(); m_ready = 1'b1; start = cyc;
      write_word(32'h55); write_word(32'h66);
      pl.push_back(32'h55); pl.push_back(32'h66); expect_frame();
      wait_beats(ed.size(), 40, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL timeout: beats=%0d, want %0d", bd.size(), ed.size());
      end else begin
         for (int i = 0; i < ed.size(); i++) begin
            checks++;
            if (bd[i] !== ed[i] || bl[i] !== el[i]) begin
               failures++;
               $display("FAIL timeout beat%0d: data=%h last=%b, want data=%h last=%b",
                        i, bd[i], bl[i], ed[i], el[i]);
            end
         end
         // fifo_empty falls at start+1; header TIMEOUT+1 cycles later
         checks++;
         if (bc[0] !== start + 1 + TIMEOUT + 1) begin
            failures++;
            $display("FAIL timeout_time: header cycle %0d, want %0d", bc[0], start + TIMEOUT + 2);
         end
      end
      tick(); tick();
   endtask

   task automatic test_backpressure();
      bit ok;
      clear_log(); m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         write_word(32'hA0 + 32'(i));
         pl.push_back(32'hA0 + 32'(i));
      end
      expect_frame();
      wait_beats(2, 20, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL backpressure_start: beats=%0d, want 2", bd.size());
      end else begin
         m_ready = 1'b0;
         for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (s_valid !== 1'b1 || s_data !== 32'hA1 || s_rd !== 1'b0 || s_last !== 1'b0) begin
               failures++;
               $display("FAIL backpressure_hold cyc%0d: valid=%b data=%h rd_en=%b last=%b, want 1 a1 0 0",
                        i, s_valid, s_data, s_rd, s_last);
            end
         end
         m_ready = 1'b1;
         wait_beats(ed.size(), 20, ok);
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL backpressure_end: beats=%0d, want %0d", bd.size(), ed.size());
         end else begin
            for (int i = 0; i < ed.size(); i++) begin
               checks++;
               if (bd[i] !== ed[i] || bl[i] !== el[i]) begin
                  failures++;
                  $display("FAIL backpressure beat%0d: data=%h last=%b, want data=%h last=%b",
                           i, bd[i], bl[i], ed[i], el[i]);
               end
            end
         end
      end
      tick(); tick();
   endtask

   task automatic test_oversize();
      bit ok;
      int h2, h3;
      clear_log(); m_ready = 1'b1;
      for (int i = 1; i <= 10; i++) write_word(32'(i));
      for (int i = 1; i <= 4; i++) pl.push_back(32'(i));
      expect_frame();
      h2 = ed.size();
      for (int i = 5; i <= 8; i++) pl.push_back(32'(i));
      expect_frame();
      h3 = ed.size();
      pl.push_back(32'd9); pl.push_back(32'd10);
      expect_frame();
      wait_beats(ed.size(), 80, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL oversize: beats=%0d, want %0d", bd.size(), ed.size());
      end else begin
         for (int i = 0; i < ed.size(); i++) begin
            checks++;
            if (bd[i] !== ed[i] || bl[i] !== el[i]) begin
               failures++;
               $display("FAIL oversize beat%0d: data=%h last=%b, want data=%h last=%b",
                        i, bd[i], bl[i], ed[i], el[i]);
            end
         end
         checks++;
         if (bc[h2] - bc[h2-1] !== 2) begin
            failures++;
            $display("FAIL oversize_gap1: header2-last1=%0d cycles, want 2", bc[h2] - bc[h2-1]);
         end
         checks++;
         if (bc[h3] - bc[h3-1] !== TIMEOUT + 2) begin
            failures++;
            $display("FAIL oversize_gap2: header3-last2=%0d cycles, want %0d", bc[h3] - bc[h3-1], TIMEOUT + 2);
         end
      end
      tick(); tick();
   endtask

   task automatic test_reset_midframe();
      bit ok;
      int r;
      clear_log(); m_ready = 1'b1;
      if (CSUM) begin
         write_word(32'h0F); write_word(32'hF0); write_word(32'hFF);
         pl.push_back(32'h0F); pl.push_back(32'hF0); pl.push_back(32'hFF);
         expect_frame();
         wait_beats(ed.size(), 40, ok);
         checks++;
         if (!ok || bd[ed.size()-1] !== 32'h0 || bl[ed.size()-1] !== 1'b1) begin
            failures++;
            $display("FAIL checksum_trailer: beats=%0d last_data=%h last=%b, want trailer 0 with last=1",
                     bd.size(), ok ? bd[ed.size()-1] : '0, ok ? bl[ed.size()-1] : 1'b0);
         end
         tick(); tick();
         clear_log();
      end
      write_word(32'h0F); write_word(32'hF0); write_word(32'hFF);
      wait_beats(3, 40, ok);
      srst_n = 1'b0;
      tick();
      checks++;
      if (s_valid !== 1'b0 || s_rd !== 1'b0) begin
         failures++;
         $display("FAIL midframe_reset: valid=%b rd_en=%b, want 0 0", s_valid, s_rd);
      end
      srst_n = 1'b1; r = cyc;
      ed.push_back(32'h8000_0003); el.push_back(1'b0);
      ed.push_back(32'h0F);        el.push_back(1'b0);
      ed.push_back(32'hF0);        el.push_back(1'b0);
      pl.push_back(32'hFF); expect_frame();
      wait_beats(ed.size(), 40, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL midframe_reframe: beats=%0d, want %0d", bd.size(), ed.size());
      end else begin
         for (int i = 0; i < ed.size(); i++) begin
            checks++;
            if (bd[i] !== ed[i] || bl[i] !== el[i]) begin
               failures++;
               $display("FAIL midframe beat%0d: data=%h last=%b, want data=%h last=%b",
                        i, bd[i], bl[i], ed[i], el[i]);
            end
         end
         checks++;
         if (bc[3] !== r + TIMEOUT + 1) begin
            failures++;
            $display("FAIL midframe_time: header cycle %0d, want %0d", bc[3], r + TIMEOUT + 1);
         end
      end
      tick(); tick();
   endtask

   initial begin
      test_reset();
      test_full_batch();
      test_timeout();
      test_backpressure();
      test_oversize();
      test_reset_midframe();
      checks++;
      if (underflows !== 0 || cnt !== 6'd0) begin
         failures++;
         $display("FAIL fifo_final: underflows=%0d occupancy=%0d, want 0 0", underflows, cnt);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
